branch_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 38 +++
 rtl/bp_sat_ctr.sv | 40 ++++
 rtl/branch_predictor.sv | 157 +++++++++++++++
 tb/tb_branch_predictor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the branch predictor.
//   upd_kind_t    : kind of control transfer reported by execute
//   idx_width()   : BTB index width for a given entry count
//   tag_width()   : BTB tag width for a given PC width and entry count
//   ctr_init()    : counter value written on allocation (weakly taken)
//   ctr_max()     : counter saturation ceiling
package bp_pkg;

    typedef enum logic [1:0] {
        UpdBr   = 2'd0,
        UpdJal  = 2'd1,
        UpdJalr = 2'd2,
        UpdNone = 2'd3
    } upd_kind_t;

    localparam int unsigned CtrWidthDefault = 2;

    function automatic int unsigned idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // PC bits [1:0] are always zero, so the tag starts above the index.
    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned entries);
        return addr_w - $clog2(entries) - 2;
    endfunction

    function automatic int unsigned ctr_init(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

    function automatic int unsigned ctr_max(input int unsigned ctr_w);
        return (32'd1 << ctr_w) - 32'd1;
    endfunction

    localparam int unsigned CtrInitDefault = 2;

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter with synchronous load, one per BTB entry.
//   clk      : clock
//   load     : overwrite with load_val (highest priority)
//   load_val : value to load
//   inc      : count up, holding at all-ones
//   dec      : count down, holding at zero
//   value    : current count
// No reset: the owning entry's valid bit makes the count meaningful.
module bp_sat_ctr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign value = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with per-entry saturating counters.
//   clk, rst                     : clock, synchronous active-high reset
//   pcf                          : fetch PC to look up
//   pred_taken_f, pred_target_f  : zero-latency prediction for pcf
//   upd_en_e, upd_kind_e, pce    : control transfer resolving in execute
//   taken_e, target_e            : its actual outcome
//   pred_taken_e, pred_target_e  : the prediction it was fetched with
//   mispredict_e, redirect_pc_e  : fetch redirect request and correct PC
//   branch_cnt, mispredict_cnt   : saturating performance counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ENTRIES       = 16,
    parameter int unsigned CTR_WIDTH     = CtrWidthDefault,
    parameter bit          PREDICT_JALR  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pcf,
    output logic                     pred_taken_f,
    output logic [ADDRESS_WIDTH-1:0] pred_target_f,
    input  logic                     upd_en_e,
    input  logic [1:0]               upd_kind_e,
    input  logic [ADDRESS_WIDTH-1:0] pce,
    input  logic                     taken_e,
    input  logic [ADDRESS_WIDTH-1:0] target_e,
    input  logic                     pred_taken_e,
    input  logic [ADDRESS_WIDTH-1:0] pred_target_e,
    output logic                     mispredict_e,
    output logic [ADDRESS_WIDTH-1:0] redirect_pc_e,
    output logic [31:0]              branch_cnt,
    output logic [31:0]              mispredict_cnt
);

    localparam int unsigned IdxW = idx_width(ENTRIES);
    localparam int unsigned TagW = tag_width(ADDRESS_WIDTH, ENTRIES);
    localparam logic [CTR_WIDTH-1:0]     CtrInit = CTR_WIDTH'(ctr_init(CTR_WIDTH));
    localparam logic [ADDRESS_WIDTH-1:0] PcStep  = ADDRESS_WIDTH'(4);

    typedef struct packed {
        logic                     valid;
        logic [TagW-1:0]          tag;
        logic [ADDRESS_WIDTH-1:0] target;
        logic [CTR_WIDTH-1:0]     ctr;
    } btb_entry_t;

    logic [ENTRIES-1:0]       valid_q;
    logic [TagW-1:0]          tag_q    [ENTRIES];
    logic [ADDRESS_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_WIDTH-1:0]     ctr_val  [ENTRIES];
    btb_entry_t               btb      [ENTRIES];

    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            btb[i] = '{valid: valid_q[i], tag: tag_q[i], target: target_q[i], ctr: ctr_val[i]};
        end
    end

    // Byte-offset bits never matter for 4-byte aligned instructions.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pcf[1:0], pce[1:0]};

    // ---------------- fetch-side lookup ----------------
    logic [IdxW-1:0] idx_f;
    logic [TagW-1:0] tag_f;
    btb_entry_t      ent_f;
    logic            hit_f;

    assign idx_f = pcf[IdxW+1:2];
    assign tag_f = pcf[ADDRESS_WIDTH-1:IdxW+2];
    assign ent_f = btb[idx_f];
    assign hit_f = ent_f.valid && (ent_f.tag == tag_f);

    // ctr >= CtrInit is exactly "counter MSB set".
    assign pred_taken_f  = !rst && hit_f && (ent_f.ctr >= CtrInit);
    assign pred_target_f = pred_taken_f ? ent_f.target : (pcf + PcStep);

    // ---------------- execute-side check and training ----------------
    upd_kind_t       kind_e;
    logic [IdxW-1:0] idx_e;
    logic [TagW-1:0] tag_e;
    btb_entry_t      ent_e;
    logic            hit_e;
    logic            check_active;
    logic            train;
    logic            train_taken;

    assign kind_e = upd_kind_t'(upd_kind_e);
    assign idx_e  = pce[IdxW+1:2];
    assign tag_e  = pce[ADDRESS_WIDTH-1:IdxW+2];
    assign ent_e  = btb[idx_e];
    assign hit_e  = ent_e.valid && (ent_e.tag == tag_e);

    assign check_active = !rst && upd_en_e && (kind_e != UpdNone);
    assign train = !rst && upd_en_e &&
                   ((kind_e == UpdBr) || (kind_e == UpdJal) ||
                    ((kind_e == UpdJalr) && PREDICT_JALR));
    // Unconditional jumps always train as taken.
    assign train_taken = (kind_e == UpdBr) ? taken_e : 1'b1;

    assign mispredict_e  = check_active &&
                           ((pred_taken_e != taken_e) ||
                            (taken_e && (pred_target_e != target_e)));
    assign redirect_pc_e = (check_active && taken_e) ? target_e : (pce + PcStep);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (train && train_taken) begin
            // A taken miss evicts whatever occupies the slot.
            if (!hit_e) begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= tag_e;
            end
            target_q[idx_e] <= target_e;
        end
    end

    for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_ctr
        logic sel;
        assign sel = train && (idx_e == IdxW'(i));

        bp_sat_ctr #(
            .WIDTH(CTR_WIDTH)
        ) u_ctr (
            .clk     (clk),
            .load    (sel && !hit_e && train_taken),
            .load_val(CtrInit),
            .inc     (sel && hit_e && train_taken),
            .dec     (sel && hit_e && !train_taken),
            .value   (ctr_val[i])
        );
    end

    // ---------------- performance counters ----------------
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (train && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict_e && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// random traffic, all compared against a behavioural BTB model.
module tb_branch_predictor;

    localparam int unsigned AW   = 32;
    localparam int unsigned NENT = 16;
    localparam int unsigned CW   = 2;
    localparam bit          PJ   = 1'b0;
    localparam int          CMAX = (1 << CW) - 1;
    localparam int          CHALF = 1 << (CW - 1);

    logic          clk;
    logic          rst;
    logic [AW-1:0] pcf;
    logic          pred_taken_f;
    logic [AW-1:0] pred_target_f;
    logic          upd_en_e;
    logic [1:0]    upd_kind_e;
    logic [AW-1:0] pce;
    logic          taken_e;
    logic [AW-1:0] target_e;
    logic          pred_taken_e;
    logic [AW-1:0] pred_target_e;
    logic          mispredict_e;
    logic [AW-1:0] redirect_pc_e;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispredict_cnt;

    branch_predictor #(
        .ADDRESS_WIDTH(AW),
        .ENTRIES      (NENT),
        .CTR_WIDTH    (CW),
        .PREDICT_JALR (PJ)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pcf           (pcf),
        .pred_taken_f  (pred_taken_f),
        .pred_target_f (pred_target_f),
        .upd_en_e      (upd_en_e),
        .upd_kind_e    (upd_kind_e),
        .pce           (pce),
        .taken_e       (taken_e),
        .target_e      (target_e),
        .pred_taken_e  (pred_taken_e),
        .pred_target_e (pred_target_e),
        .mispredict_e  (mispredict_e),
        .redirect_pc_e (redirect_pc_e),
        .branch_cnt    (branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: one slot per (pc/4) mod NENT, tag = pc / (4*NENT).
    bit          m_valid [NENT];
    logic [31:0] m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    int unsigned m_bcnt  = 0;
    int unsigned m_mcnt  = 0;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * NENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        tk  = m_hit(pc) && (m_ctr[slot_of(pc)] >= CHALF);
        tgt = tk ? m_tgt[slot_of(pc)] : pc + 32'd4;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs before the edge,
    // then advance the model across the edge.
    task automatic cycle(input logic r, input logic [31:0] pf, input logic en,
                         input logic [1:0] kind, input logic [31:0] pc_e,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        active;
        logic        e_mp;
        logic [31:0] e_rd;
        bit          elig;
        bit          t;
        int          s;
        rst = r; pcf = pf; upd_en_e = en; upd_kind_e = kind; pce = pc_e;
        taken_e = tk; target_e = tgt; pred_taken_e = ptk; pred_target_e = ptgt;
        @(negedge clk);
        m_lookup(pf, e_ptk, e_ptgt);
        if (r) begin
            e_ptk  = 1'b0;
            e_ptgt = pf + 32'd4;
        end
        active = !r && en && (kind != 2'd3);
        e_mp   = active && ((ptk != tk) || (tk && (ptgt != tgt)));
        e_rd   = (active && tk) ? tgt : pc_e + 32'd4;
        check("pred_taken_f",   {31'd0, pred_taken_f}, {31'd0, e_ptk});
        check("pred_target_f",  pred_target_f, e_ptgt);
        check("mispredict_e",   {31'd0, mispredict_e}, {31'd0, e_mp});
        check("redirect_pc_e",  redirect_pc_e, e_rd);
        check("branch_cnt",     branch_cnt, m_bcnt);
        check("mispredict_cnt", mispredict_cnt, m_mcnt);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < int'(NENT); i++) m_valid[i] = 1'b0;
            m_bcnt = 0;
            m_mcnt = 0;
        end else begin
            if (e_mp) m_mcnt++;
            elig = en && ((kind == 2'd0) || (kind == 2'd1) || ((kind == 2'd2) && PJ));
            if (elig) begin
                m_bcnt++;
                t = (kind == 2'd0) ? tk : 1'b1;
                s = slot_of(pc_e);
                if (m_hit(pc_e)) begin
                    if (t) begin
                        m_ctr[s] = (m_ctr[s] == CMAX) ? CMAX : m_ctr[s] + 1;
                        m_tgt[s] = tgt;
                    end else begin
                        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (t) begin
                    m_valid[s] = 1'b1;
                    m_tag[s]   = tag_of(pc_e);
                    m_tgt[s]   = tgt;
                    m_ctr[s]   = CHALF;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] pf);
        cycle(1'b0, pf, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        logic [31:0] rpf;
        logic [31:0] rtgt;
        logic [1:0]  rkind;
        logic        rtk;
        logic        mtk;
        logic [31:0] mtgt;
        for (int i = 0; i < int'(NENT); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end

        // Reset, then an empty lookup.
        cycle(1'b1, 32'h100, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h4);
        idle(32'h100);

        // Taken branch 0x100 -> 0x80 allocates weakly taken.
        cycle(1'b0, 32'h100, 1'b1, 2'd0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        idle(32'h100);

        // Not-taken training, then saturation at zero.
        cycle(1'b0, 32'h100, 1'b1, 2'd0, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        idle(32'h100);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h100, 1'b1, 2'd0, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
        end
        cycle(1'b0, 32'h100, 1'b1, 2'd0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        idle(32'h100);

        // jal at 0x100 then 0x140: same slot, different tag, eviction.
        cycle(1'b0, 32'h100, 1'b1, 2'd1, 32'h100, 1'b1, 32'h400, 1'b0, 32'h104);
        cycle(1'b0, 32'h140, 1'b1, 2'd1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
        idle(32'h100);
        idle(32'h140);

        // Same-cycle lookup and update at 0x200: no bypass.
        cycle(1'b0, 32'h200, 1'b1, 2'd0, 32'h200, 1'b1, 32'h240, 1'b0, 32'h204);
        idle(32'h200);

        // jalr never allocates, but still mispredicts.
        cycle(1'b0, 32'h2c0, 1'b1, 2'd2, 32'h2c0, 1'b1, 32'h300, 1'b0, 32'h2c4);
        idle(32'h2c0);

        // Reserved kind: no check, no training.
        cycle(1'b0, 32'h180, 1'b1, 2'd3, 32'h180, 1'b1, 32'h900, 1'b0, 32'h184);
        idle(32'h180);

        // Reset with an update in flight: update discarded, counters cleared.
        cycle(1'b1, 32'h200, 1'b1, 2'd1, 32'h1c0, 1'b1, 32'h700, 1'b0, 32'h1c4);
        idle(32'h200);
        idle(32'h1c0);

        // Random traffic over a pool that aliases heavily onto the 16 slots.
        for (int n = 0; n < 400; n++) begin
            rpc   = 32'h100 + ($urandom_range(0, 63) << 2);
            rpf   = 32'h100 + ($urandom_range(0, 63) << 2);
            rtgt  = ($urandom_range(0, 7) < 6) ? (32'h1000 + ($urandom_range(0, 3) << 4))
                                               : ($urandom & 32'hffff_fffc);
            rkind = 2'($urandom_range(0, 3));
            rtk   = 1'($urandom_range(0, 1));
            m_lookup(rpc, mtk, mtgt);
            if ($urandom_range(0, 4) == 0) begin
                mtk  = 1'($urandom_range(0, 1));
                mtgt = $urandom & 32'hffff_fffc;
            end
            cycle(($urandom_range(0, 60) == 0), rpf, 1'($urandom_range(0, 3) != 0), rkind,
                  rpc, rtk, rtgt, mtk, mtgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
